// File: rtl/edge_pkg.sv
// Shared types and defaults for the pixel SRAM arbiter: FSM states, requester IDs,
// default bus widths and the tie-break helper.
package edge_pkg;

    localparam int DEFAULT_ADDR_BITS = 16;
    localparam int DEFAULT_DATA_BITS = 24;
    localparam int TIMER_BITS        = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_id_t;

    // On a tie, the requester that was not served last wins.
    function automatic arb_state_t pick_grant(input logic rd, input logic wr, input req_id_t last);
        if (rd && wr) return (last == REQ_RD) ? WRITE : READ;
        if (rd)       return READ;
        if (wr)       return WRITE;
        return IDLE;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side handshake bundle for sram_port_arbiter: the read (pixel fetch)
// and write (result writeback) request/ack channels.
interface sram_port_arbiter_if #(
    parameter int ADDR_BITS = edge_pkg::DEFAULT_ADDR_BITS,
    parameter int DATA_BITS = edge_pkg::DEFAULT_DATA_BITS
);
    logic                 rd_req;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 rd_ack;
    logic [DATA_BITS-1:0] rd_rdata;

    logic                 wr_req;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_wdata;
    logic                 wr_ack;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_wdata,
        input  rd_ack, rd_rdata, wr_ack
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_wdata,
        output rd_ack, rd_rdata, wr_ack
    );
endinterface

// File: rtl/flex_counter.sv
// Clearable up-counter that wraps from rollover_val back to 1; rollover_flag is
// registered and high while the count equals rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        count_d = count_q;
        flag_d  = flag_q;
        if (clear) begin
            count_d = '0;
            flag_d  = 1'b0;
        end else if (count_enable) begin
            count_d = (count_q == rollover_val) ? NUM_CNT_BITS'(1) : count_q + NUM_CNT_BITS'(1);
            flag_d  = (count_d == rollover_val);
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign rollover_flag = flag_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the single-port pixel SRAM between the read (fetch) and write (writeback)
// requesters. Optional grant counters are built when SRAM_ARB_PERF_EN is defined.
module sram_port_arbiter
    import edge_pkg::*;
#(
    parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int ACCESS_CYCLES = 5,
    parameter int PERF_BITS     = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    sram_port_arbiter_if.slave   req_if,
    output logic [ADDR_BITS-1:0] sram_address,
    output logic [DATA_BITS-1:0] sram_w_data,
    input  logic [DATA_BITS-1:0] sram_r_data,
    output logic                 sram_read_enable,
    output logic                 sram_write_enable,
    output logic                 busy
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [PERF_BITS-1:0] rd_grants,
    output logic [PERF_BITS-1:0] wr_grants
`endif
);

    if (ACCESS_CYCLES < 3 || ACCESS_CYCLES > 15 || PERF_BITS < 1) begin : g_bad_params
        $error("sram_port_arbiter: ACCESS_CYCLES must be 3..15 and PERF_BITS >= 1");
    end

    arb_state_t           state_q, state_d;
    req_id_t              last_grant_q, last_grant_d;
    logic [ADDR_BITS-1:0] address_q, address_d;
    logic [DATA_BITS-1:0] w_data_q, w_data_d;
    logic [DATA_BITS-1:0] rd_rdata_q, rd_rdata_d;
    logic                 read_enable_q, read_enable_d;
    logic                 write_enable_q, write_enable_d;
    logic                 rd_ack_q, rd_ack_d;
    logic                 wr_ack_q, wr_ack_d;
    logic                 busy_q, busy_d;

    logic timer_clear, timer_enable, timer_done;

    // The grant edge already counts as tick 1, so the flag rises on the last enable cycle.
    flex_counter #(.NUM_CNT_BITS(TIMER_BITS)) u_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (timer_clear),
        .count_enable (timer_enable),
        .rollover_val (TIMER_BITS'(ACCESS_CYCLES)),
        .rollover_flag(timer_done)
    );

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        address_d      = address_q;
        w_data_d       = w_data_q;
        rd_rdata_d     = rd_rdata_q;
        read_enable_d  = 1'b0;
        write_enable_d = 1'b0;
        rd_ack_d       = 1'b0;
        wr_ack_d       = 1'b0;
        timer_clear    = 1'b0;
        timer_enable   = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = pick_grant(req_if.rd_req, req_if.wr_req, last_grant_q);
                case (state_d)
                    READ: begin
                        address_d     = req_if.rd_addr;
                        read_enable_d = 1'b1;
                        timer_enable  = 1'b1;
                    end
                    WRITE: begin
                        address_d      = req_if.wr_addr;
                        w_data_d       = req_if.wr_wdata;
                        write_enable_d = 1'b1;
                        timer_enable   = 1'b1;
                    end
                    default: timer_clear = 1'b1;
                endcase
            end
            READ, WRITE: begin
                timer_enable = 1'b1;
                if (timer_done) begin
                    state_d = DONE;
                    if (state_q == READ) begin
                        rd_rdata_d   = sram_r_data;
                        rd_ack_d     = 1'b1;
                        last_grant_d = REQ_RD;
                    end else begin
                        wr_ack_d     = 1'b1;
                        last_grant_d = REQ_WR;
                    end
                end else begin
                    read_enable_d  = (state_q == READ);
                    write_enable_d = (state_q == WRITE);
                end
            end
            DONE: begin
                state_d     = IDLE;
                timer_clear = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                timer_clear = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            last_grant_q   <= REQ_WR;
            address_q      <= '0;
            w_data_q       <= '0;
            rd_rdata_q     <= '0;
            read_enable_q  <= 1'b0;
            write_enable_q <= 1'b0;
            rd_ack_q       <= 1'b0;
            wr_ack_q       <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            address_q      <= address_d;
            w_data_q       <= w_data_d;
            rd_rdata_q     <= rd_rdata_d;
            read_enable_q  <= read_enable_d;
            write_enable_q <= write_enable_d;
            rd_ack_q       <= rd_ack_d;
            wr_ack_q       <= wr_ack_d;
            busy_q         <= busy_d;
        end
    end

    assign sram_address      = address_q;
    assign sram_w_data       = w_data_q;
    assign sram_read_enable  = read_enable_q;
    assign sram_write_enable = write_enable_q;
    assign busy              = busy_q;
    assign req_if.rd_rdata   = rd_rdata_q;
    assign req_if.rd_ack     = rd_ack_q;
    assign req_if.wr_ack     = wr_ack_q;

`ifdef SRAM_ARB_PERF_EN
    logic [PERF_BITS-1:0] rd_grants_q, rd_grants_d;
    logic [PERF_BITS-1:0] wr_grants_q, wr_grants_d;

    // Counters step on the same edge that raises the ack and stick at all-ones.
    always_comb begin
        rd_grants_d = rd_grants_q;
        wr_grants_d = wr_grants_q;
        if (rd_ack_d && !(&rd_grants_q)) rd_grants_d = rd_grants_q + PERF_BITS'(1);
        if (wr_ack_d && !(&wr_grants_q)) wr_grants_d = wr_grants_q + PERF_BITS'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_grants_q <= '0;
            wr_grants_q <= '0;
        end else begin
            rd_grants_q <= rd_grants_d;
            wr_grants_q <= wr_grants_d;
        end
    end

    assign rd_grants = rd_grants_q;
    assign wr_grants = wr_grants_q;
`endif

endmodule
